atomic_exec_controller: RTL and testbench
=========================================

// Module: atomic_exec_controller
// PURPOSE
//  Parametrised successor to the fixed 8x32 FSM controller. Owns a NUM_REGS x DATA_W
//  register file, accepts commands over a valid/ready handshake, drives the external
//  combinational ALU and writes results back. Supports atomic compare-and-swap (CAS)
//  and a selectable write-back mode. Sits between the command source and the ALU.
// PARAMETERS
//  DATA_W      32                  register / ALU operand width
//  NUM_REGS    8                   register count, power of two, >=2
//  ADDR_W      $clog2(NUM_REGS)    register address width (derived)
//  CMD_W       3+3*ADDR_W          command width (derived): {op[2:0],a1,a2,a3}
//  WB_TO_ADDR3 1                   1: ALU result -> reg[a3]; 0: result -> reg[NUM_REGS-1] (legacy)
// PORTS
//  clk               in   1         clock, rising edge
//  rst_n             in   1         asynchronous reset, active low
//  cmd_valid         in   1         command present
//  cmd_ready         out  1         controller idle, can accept
//  command           in   CMD_W     {op,a1,a2,a3}; sampled on accept
//  alu_op_code       out  3         ALU opcode (registered)
//  data_a, data_b    out  DATA_W    ALU operands (registered)
//  y                 in   DATA_W    ALU result (combinational from data_a/b/op)
//  Z                 in   1         ALU zero flag for y
//  done              out  1         one-cycle completion pulse
//  result            out  DATA_W    value written back (ALU ops) / reg[a1] old value (CAS)
//  cas_success       out  1         valid with done; 1 = CAS swapped
//  dbg_addr          in   ADDR_W    debug read address
//  dbg_data          out  DATA_W    reg[dbg_addr], combinational
//  register_out_last out  DATA_W    reg[NUM_REGS-1], combinational
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all registers=0; alu_op_code=0; data_a=data_b=0;
//   done=0; result=0; cas_success=0; latched command=0. Any in-flight op is aborted, no done.
//  cmd_ready = (state==IDLE). Accept on edge with cmd_valid&&cmd_ready; command latched.
//   cmd_valid while busy is ignored (no queueing); source must hold until accepted.
//  States: IDLE, DECODE, EXECUTE, CAS_CMP, COMPLETE.
//   IDLE    -accept-> DECODE.
//   DECODE  -> op==3'b111 ? CAS_CMP : EXECUTE. On this edge load data_a=reg[a1],
//            data_b=reg[a2]; alu_op_code = op (ALU ops) or 3'b001 subtract (CAS).
//   EXECUTE -> COMPLETE. On edge: dest<=y (dest = a3 or NUM_REGS-1 per WB_TO_ADDR3),
//            result<=y, cas_success<=0.
//   CAS_CMP -> COMPLETE. On edge: if Z, reg[a1]<=reg[a3] and reg[a3]<=reg[a1]
//            simultaneously (nonblocking); cas_success<=Z; result<=old reg[a1].
//   COMPLETE: done=1 for exactly this cycle -> IDLE.
//  Latency: accept edge E0; done high in cycle after E2; cmd_ready high again after E3.
//   Throughput one command per 4 cycles; back-to-back accept legal on cycle after COMPLETE.
//  Register writes only at EXECUTE/CAS_CMP exit edges; no other write path.
//  Edge cases: a1==a3 on CAS with Z=1 -> no change, cas_success=1. Dest==a1/a2 -> operands
//   already captured, write is safe. Wrap/overflow is the ALU's concern; stored as-is in DATA_W.
//  data_a/data_b/alu_op_code hold last values in IDLE/COMPLETE (no return to zero).
//  result/cas_success hold until next completion.
// TESTING
//  T1 reset mid-EXECUTE (rst_n low 1 cycle) -> regs all 0, no done, cmd_ready=1 next cycle.
//  T2 preload r1=5,r2=3 via ADD op 000 with ALU model; cmd {000,1,2,4} -> r4=8, done 3 cycles
//     after accept, result=8, register_out_last unchanged (WB_TO_ADDR3=1).
//  T3 CAS hit: r1=7,r2=7,r3=9, cmd {111,1,2,3} -> alu_op_code=001, r1=9, r3=7, cas_success=1.
//  T4 CAS miss: r1=7,r2=6,r3=9 -> regs unchanged, cas_success=0, result=7.
//  T5 cmd_valid held high across busy period with second command -> second accepted only
//     after COMPLETE, exactly one done per command, no command lost or duplicated.
//  T6 WB_TO_ADDR3=0, NUM_REGS=16, DATA_W=16: cmd {000,1,2,3} -> r15=sum, r3 untouched.

Source files
------------

// File: rtl/atomic_exec_controller.sv
// atomic_exec_controller
//   Register-file controller that sequences an external combinational ALU.
//   Commands {op,a1,a2,a3} are accepted over a valid/ready handshake, operands
//   are read from the internal NUM_REGS x DATA_W register file, and the ALU result
//   is written back. op 3'b111 is an atomic compare-and-swap: if reg[a1]==reg[a2]
//   (ALU subtract gives Z), reg[a1] and reg[a3] are exchanged.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; cmd_ready high only when idle
//   command             {op[2:0], a1, a2, a3}, latched on accept
//   alu_op_code         registered ALU opcode
//   data_a, data_b      registered ALU operands
//   y, Z                ALU result and zero flag (combinational from the operands)
//   done                one-cycle completion pulse
//   result              written-back value (ALU ops) or old reg[a1] (CAS)
//   cas_success         CAS outcome, valid with done
//   dbg_addr/dbg_data   combinational debug read port
//   register_out_last   reg[NUM_REGS-1], combinational
module atomic_exec_controller #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter bit          WB_TO_ADDR3 = 1'b1,
  localparam int unsigned ADDR_W     = $clog2(NUM_REGS),
  localparam int unsigned CMD_W      = 3 + 3 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  command,
  output logic [2:0]        alu_op_code,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic [DATA_W-1:0] y,
  input  logic              Z,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cas_success,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] register_out_last
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    CAS_CMP,
    COMPLETE
  } state_t;

  localparam logic [2:0] OP_CAS = 3'b111;
  localparam logic [2:0] OP_SUB = 3'b001;

  state_t              state;
  state_t              next_state;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [2:0]          op;
  logic [ADDR_W-1:0]   a1;
  logic [ADDR_W-1:0]   a2;
  logic [ADDR_W-1:0]   a3;
  logic [ADDR_W-1:0]   dest;

  assign op = cmd_q[CMD_W-1 -: 3];
  assign a1 = cmd_q[3*ADDR_W-1 -: ADDR_W];
  assign a2 = cmd_q[2*ADDR_W-1 -: ADDR_W];
  assign a3 = cmd_q[ADDR_W-1:0];

  // Legacy mode always writes the ALU result to the last register.
  assign dest = WB_TO_ADDR3 ? a3 : ADDR_W'(NUM_REGS - 1);

  assign dbg_data          = regs[dbg_addr];
  assign register_out_last = regs[NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = DECODE;
      end
      DECODE:   next_state = (op == OP_CAS) ? CAS_CMP : EXECUTE;
      EXECUTE:  next_state = COMPLETE;
      CAS_CMP:  next_state = COMPLETE;
      COMPLETE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      alu_op_code <= '0;
      data_a      <= '0;
      data_b      <= '0;
      result      <= '0;
      cas_success <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) cmd_q <= command;
        end
        DECODE: begin
          data_a      <= regs[a1];
          data_b      <= regs[a2];
          // CAS compares by subtraction; equality is read back through Z.
          alu_op_code <= (op == OP_CAS) ? OP_SUB : op;
        end
        EXECUTE: begin
          result      <= y;
          cas_success <= 1'b0;
        end
        CAS_CMP: begin
          result      <= regs[a1];
          cas_success <= Z;
        end
        default: ;
      endcase
    end
  end

  // Operands were captured in DECODE, so a destination aliasing a1/a2 is safe.
  // The CAS swap reads both old values; a1==a3 degenerates to a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (state == EXECUTE) begin
      regs[dest] <= y;
    end else if (state == CAS_CMP && Z) begin
      regs[a1] <= regs[a3];
      regs[a3] <= regs[a1];
    end
  end

endmodule

// File: tb/tb_atomic_exec_controller.sv
module tb_atomic_exec_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        cas;
  } exp_t;

  // ---------------- instance 1: 8 x 32, write-back to a3 ----------------
  logic        cmd_valid, cmd_ready, done, cas_success, z;
  logic [11:0] command;
  logic [2:0]  alu_op_code, dbg_addr;
  logic [31:0] data_a, data_b, y, result, dbg_data, register_out_last, imm;
  logic [31:0] m1 [8];
  exp_t        sb [$];
  int          done_cnt = 0;

  atomic_exec_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .command(command), .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
    .y(y), .Z(z), .done(done), .result(result), .cas_success(cas_success),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .register_out_last(register_out_last)
  );

  // External ALU: 000 add, 001 sub, 110 load immediate, others xor.
  always_comb begin
    case (alu_op_code)
      3'b000:  y = data_a + data_b;
      3'b001:  y = data_a - data_b;
      3'b110:  y = imm;
      default: y = data_a ^ data_b;
    endcase
  end
  assign z = (y == '0);

  // ---------------- instance 2: 16 x 16, legacy write-back ----------------
  logic        cmd_valid2, cmd_ready2, done2, cas_success2, z2;
  logic [14:0] command2;
  logic [2:0]  alu_op_code2;
  logic [3:0]  dbg_addr2;
  logic [15:0] data_a2, data_b2, y2, result2, dbg_data2, register_out_last2, imm2;
  logic [15:0] m2 [16];
  exp_t        q2 [$];

  atomic_exec_controller #(.DATA_W(16), .NUM_REGS(16), .WB_TO_ADDR3(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .command(command2), .alu_op_code(alu_op_code2), .data_a(data_a2), .data_b(data_b2),
    .y(y2), .Z(z2), .done(done2), .result(result2), .cas_success(cas_success2),
    .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .register_out_last(register_out_last2)
  );

  always_comb begin
    case (alu_op_code2)
      3'b000:  y2 = data_a2 + data_b2;
      3'b001:  y2 = data_a2 - data_b2;
      3'b110:  y2 = imm2;
      default: y2 = data_a2 ^ data_b2;
    endcase
  end
  assign z2 = (y2 == '0);

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for instance 1: pops one expectation per done pulse.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", result, mon_e.res);
        chk("sb_cas", cas_success, mon_e.cas);
      end
    end
  end

  task automatic predict1(input logic [2:0] op, input int unsigned a1, a2, a3,
                          input logic [31:0] imm_v, output logic [31:0] ea, output logic [31:0] eb);
    exp_t e;
    logic [31:0] ey;
    ea = m1[a1];
    eb = m1[a2];
    if (op == 3'b111) begin
      e.res = ea;
      e.cas = (ea == eb);
      if (e.cas) begin
        m1[a1] = m1[a3];
        m1[a3] = ea;
      end
    end else begin
      case (op)
        3'b000:  ey = ea + eb;
        3'b001:  ey = ea - eb;
        3'b110:  ey = imm_v;
        default: ey = ea ^ eb;
      endcase
      m1[a3] = ey;
      e.res  = ey;
      e.cas  = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Drive a command, wait for it to be accepted, return at the negedge after acceptance.
  task automatic start1(input logic [2:0] op, input int unsigned a1, a2, a3);
    int n = 0;
    cmd_valid = 1'b1;
    command   = {op, 3'(a1), 3'(a2), 3'(a3)};
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue1(input logic [2:0] op, input int unsigned a1, a2, a3, input logic [31:0] imm_v);
    logic [31:0] ea, eb;
    imm = imm_v;
    predict1(op, a1, a2, a3, imm_v, ea, eb);
    start1(op, a1, a2, a3);
    chk("busy_not_ready", cmd_ready, 1'b0);
    chk("n1_done", done, 1'b0);
    @(negedge clk);
    chk("data_a", data_a, ea);
    chk("data_b", data_b, eb);
    chk("alu_op", alu_op_code, (op == 3'b111) ? 3'b001 : op);
    chk("n2_done", done, 1'b0);
    @(negedge clk);
    chk("n3_done", done, 1'b1);
    @(negedge clk);
    chk("ready_again", cmd_ready, 1'b1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic check_regs1(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, dbg_data, m1[i]);
    end
    chk("reg_out_last", register_out_last, m1[7]);
    @(negedge clk);
  endtask

  task automatic issue2(input logic [2:0] op, input int unsigned a1, a2, a3, input logic [15:0] imm_v);
    exp_t e;
    logic [15:0] ea, eb, ey;
    int n = 0;
    ea = m2[a1];
    eb = m2[a2];
    if (op == 3'b111) begin
      e.res = 32'(ea);
      e.cas = (ea == eb);
      if (e.cas) begin
        m2[a1] = m2[a3];
        m2[a3] = ea;
      end
    end else begin
      case (op)
        3'b000:  ey = ea + eb;
        3'b001:  ey = ea - eb;
        3'b110:  ey = imm_v;
        default: ey = ea ^ eb;
      endcase
      m2[15] = ey;
      e.res  = 32'(ey);
      e.cas  = 1'b0;
    end
    q2.push_back(e);
    imm2       = imm_v;
    cmd_valid2 = 1'b1;
    command2   = {op, 4'(a1), 4'(a2), 4'(a3)};
    while (cmd_ready2 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done", done2, 1'b1);
    e = q2.pop_front();
    chk("t6_result", 32'(result2), e.res);
    chk("t6_cas", cas_success2, e.cas);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea, eb;
    int base, n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; command = '0; dbg_addr = '0; imm = '0;
    cmd_valid2 = 1'b0; command2 = '0; dbg_addr2 = '0; imm2 = '0;
    for (int i = 0; i < 8; i++) m1[i] = '0;
    for (int i = 0; i < 16; i++) m2[i] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_cas", cas_success, 1'b0);
    chk("rst_alu_op", alu_op_code, 3'b000);
    chk("rst_data_a", data_a, 32'h0);
    chk("rst_data_b", data_b, 32'h0);
    chk("rst_ready2", cmd_ready2, 1'b1);
    chk("rst_last2", register_out_last2, 16'h0);
    check_regs1("rst_reg");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload, then reset in the middle of EXECUTE
    issue1(3'b110, 0, 0, 1, 32'd5);
    issue1(3'b110, 0, 0, 2, 32'd3);
    issue1(3'b110, 0, 0, 7, 32'h1234);
    check_regs1("preload_reg");
    start1(3'b000, 1, 2, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m1[i] = '0;
    chk("t1_ready", cmd_ready, 1'b1);
    chk("t1_done", done, 1'b0);
    chk("t1_result", result, 32'h0);
    check_regs1("t1_reg");
    rst_n = 1'b1;
    chk("t1_done_rel", done, 1'b0);
    @(negedge clk);
    chk("t1_ready_next", cmd_ready, 1'b1);
    chk("t1_no_done", done, 1'b0);
    chk("t1_done_count", done_cnt, 3);

    // T2 ADD with write-back to a3
    issue1(3'b110, 0, 0, 1, 32'd5);
    issue1(3'b110, 0, 0, 2, 32'd3);
    issue1(3'b110, 0, 0, 7, 32'hABCD);
    issue1(3'b000, 1, 2, 4, 32'h0);
    chk("t2_r4", m1[4], 32'd8);
    check_regs1("t2_reg");

    // T3 CAS hit
    issue1(3'b110, 0, 0, 1, 32'd7);
    issue1(3'b110, 0, 0, 2, 32'd7);
    issue1(3'b110, 0, 0, 3, 32'd9);
    issue1(3'b111, 1, 2, 3, 32'h0);
    chk("t3_cas", cas_success, 1'b1);
    check_regs1("t3_reg");

    // T4 CAS miss
    issue1(3'b110, 0, 0, 1, 32'd7);
    issue1(3'b110, 0, 0, 2, 32'd6);
    issue1(3'b110, 0, 0, 3, 32'd9);
    issue1(3'b111, 1, 2, 3, 32'h0);
    chk("t4_cas", cas_success, 1'b0);
    chk("t4_result", result, 32'd7);
    check_regs1("t4_reg");

    // Edge cases: CAS with a1==a3, destination aliasing a1, subtract wrap
    issue1(3'b110, 0, 0, 5, 32'd4);
    issue1(3'b111, 5, 5, 5, 32'h0);
    issue1(3'b000, 1, 2, 1, 32'h0);
    issue1(3'b001, 0, 5, 6, 32'h0);
    check_regs1("edge_reg");

    // T5 cmd_valid held across the busy period with a dependent second command
    base = done_cnt;
    predict1(3'b000, 1, 2, 6, 32'h0, ea, eb);
    predict1(3'b001, 6, 1, 0, 32'h0, ea, eb);
    start1(3'b000, 1, 2, 6);
    cmd_valid = 1'b1;
    command   = {3'b001, 3'd6, 3'd1, 3'd0};
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_second_wait", n, 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_sb_drained", sb.size(), 0);
    repeat (6) @(negedge clk);
    chk("t5_done_count", done_cnt - base, 2);
    check_regs1("t5_reg");

    // T6 legacy write-back, 16 x 16; CAS swaps move values out of r15
    issue2(3'b110, 0, 0, 3, 16'hFFF0);
    issue2(3'b111, 15, 15, 1, 16'h0);
    issue2(3'b110, 0, 0, 3, 16'h0020);
    issue2(3'b111, 15, 15, 2, 16'h0);
    issue2(3'b110, 0, 0, 3, 16'h0333);
    issue2(3'b111, 15, 15, 3, 16'h0);
    issue2(3'b000, 1, 2, 3, 16'h0);
    chk("t6_r15", register_out_last2, 16'h0010);
    for (int i = 0; i < 16; i++) begin
      dbg_addr2 = 4'(i);
      #1;
      chk("t6_reg", dbg_data2, m2[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
